// File: rtl/dma_wr_split.sv
// dma_wr_split
// Splits one write command (start address + beat count) into AXI4 INCR bursts
// of at most BL beats that never cross a 4 KB page, streams the payload straight
// through to the W channel, and collects one B response per burst. A one-cycle
// done pulse (with the accumulated error flag) closes out the command.
//
// Ports
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   cmd_addr/beats/id        command (address AXI_BYTES-aligned, beats >= 1)
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   src_data/valid/ready     payload stream, passed combinationally to W
//   usr_aw*                  AXI write address channel
//   usr_w*                   AXI write data channel
//   usr_b*                   AXI write response channel
//   done, err                completion pulse and error flag (err valid with done)
module dma_wr_split #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int BL     = 16,
    parameter int CNTW   = 16,
    localparam int AXI_BYTES = AXI_DW / 8
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,

    input  logic [AXI_AW-1:0]    cmd_addr,
    input  logic [CNTW-1:0]      cmd_beats,
    input  logic [AXI_IW-1:0]    cmd_id,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,

    input  logic [AXI_DW-1:0]    src_data,
    input  logic                 src_valid,
    output logic                 src_ready,

    output logic [AXI_IW-1:0]    usr_awid,
    output logic [AXI_AW-1:0]    usr_awaddr,
    output logic [AXI_LW-1:0]    usr_awlen,
    output logic [2:0]           usr_awsize,
    output logic [1:0]           usr_awburst,
    output logic                 usr_awvalid,
    input  logic                 usr_awready,

    output logic [AXI_DW-1:0]    usr_wdata,
    output logic [AXI_BYTES-1:0] usr_wstrb,
    output logic                 usr_wlast,
    output logic                 usr_wvalid,
    input  logic                 usr_wready,

    input  logic [AXI_IW-1:0]    usr_bid,
    input  logic [1:0]           usr_bresp,
    input  logic                 usr_bvalid,
    output logic                 usr_bready,

    output logic                 done,
    output logic                 err
);

    localparam int SIZE_LOG2 = $clog2(AXI_BYTES);
    localparam int BCW       = AXI_LW + 1;   // holds a full BL-beat count

    typedef enum logic [1:0] {IDLE, AW, W, RESP} state_t;

    state_t              state_reg;
    logic [AXI_AW-1:0]   addr_reg;
    logic [CNTW-1:0]     remaining_reg;
    logic [CNTW-1:0]     issued_reg;
    logic [CNTW-1:0]     resp_reg;
    logic [AXI_IW-1:0]   id_reg;
    logic [BCW-1:0]      beats_left_reg;
    logic                err_reg;
    logic                done_reg;

    // Burst length for the next AW: the smallest of what is left, BL, and the
    // beats remaining before the next 4 KB page. Derived only from registers,
    // so the AW payload stays stable while waiting for usr_awready.
    logic [12:0] page_room;
    logic [31:0] room_beats;
    logic [31:0] burst_beats;

    always_comb begin
        page_room   = 13'd4096 - {1'b0, addr_reg[11:0]};
        room_beats  = 32'(page_room >> SIZE_LOG2);
        burst_beats = 32'(BL);
        if (room_beats < burst_beats)
            burst_beats = room_beats;
        if (32'(remaining_reg) < burst_beats)
            burst_beats = 32'(remaining_reg);
    end

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic last_beat;

    assign aw_hs     = usr_awvalid & usr_awready;
    assign w_hs      = usr_wvalid & usr_wready;
    assign b_hs      = usr_bvalid & usr_bready;
    assign last_beat = (beats_left_reg == BCW'(1));

    assign cmd_ready   = (state_reg == IDLE);

    assign usr_awvalid = (state_reg == AW);
    assign usr_awid    = id_reg;
    assign usr_awaddr  = addr_reg;
    assign usr_awlen   = AXI_LW'(burst_beats - 32'd1);
    assign usr_awsize  = 3'(SIZE_LOG2);
    assign usr_awburst = 2'b01;

    // Zero-latency payload path: the source sees the slave's ready directly.
    assign usr_wvalid  = (state_reg == W) & src_valid;
    assign src_ready   = (state_reg == W) & usr_wready;
    assign usr_wdata   = src_data;
    assign usr_wstrb   = '1;
    assign usr_wlast   = (state_reg == W) & last_beat;

    // Responses for earlier bursts may arrive while later ones are in flight.
    assign usr_bready  = (state_reg != IDLE);

    assign done = done_reg;
    assign err  = err_reg;

    // Response ID and OKAY/EXOKAY distinction are not needed: one ID per command.
    logic unused_inputs;
    assign unused_inputs = ^{usr_bid, usr_bresp[0]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            remaining_reg  <= '0;
            issued_reg     <= '0;
            resp_reg       <= '0;
            id_reg         <= '0;
            beats_left_reg <= '0;
            err_reg        <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            // B channel runs independently of the AW/W progress.
            if (b_hs) begin
                resp_reg <= resp_reg + CNTW'(1);
                if (usr_bresp[1])
                    err_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_reg      <= cmd_addr;
                        remaining_reg <= cmd_beats;
                        id_reg        <= cmd_id;
                        issued_reg    <= '0;
                        resp_reg      <= '0;
                        err_reg       <= 1'b0;
                        state_reg     <= AW;
                    end
                end
                AW: begin
                    if (aw_hs) begin
                        issued_reg     <= issued_reg + CNTW'(1);
                        addr_reg       <= addr_reg + AXI_AW'(burst_beats << SIZE_LOG2);
                        remaining_reg  <= remaining_reg - CNTW'(burst_beats);
                        beats_left_reg <= BCW'(burst_beats);
                        state_reg      <= W;
                    end
                end
                W: begin
                    if (w_hs) begin
                        beats_left_reg <= beats_left_reg - BCW'(1);
                        if (last_beat)
                            state_reg <= (remaining_reg == '0) ? RESP : AW;
                    end
                end
                RESP: begin
                    // A response landing this cycle may be the one that completes.
                    if ((resp_reg + CNTW'(b_hs)) == issued_reg) begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_wr_split.sv
module tb_dma_wr_split;

    localparam int DW   = 128;
    localparam int AW   = 32;
    localparam int IW   = 8;
    localparam int LW   = 8;
    localparam int BLEN = 16;
    localparam int CW   = 16;
    localparam int NB   = DW / 8;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [AW-1:0]   cmd_addr;
    logic [CW-1:0]   cmd_beats;
    logic [IW-1:0]   cmd_id;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [DW-1:0]   src_data;
    logic            src_valid;
    logic            src_ready;
    logic [IW-1:0]   usr_awid;
    logic [AW-1:0]   usr_awaddr;
    logic [LW-1:0]   usr_awlen;
    logic [2:0]      usr_awsize;
    logic [1:0]      usr_awburst;
    logic            usr_awvalid;
    logic            usr_awready;
    logic [DW-1:0]   usr_wdata;
    logic [NB-1:0]   usr_wstrb;
    logic            usr_wlast;
    logic            usr_wvalid;
    logic            usr_wready;
    logic [IW-1:0]   usr_bid;
    logic [1:0]      usr_bresp;
    logic            usr_bvalid;
    logic            usr_bready;
    logic            done;
    logic            err;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    dma_wr_split #(
        .AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .BL(BLEN), .CNTW(CW)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_id(cmd_id),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .usr_awid(usr_awid), .usr_awaddr(usr_awaddr), .usr_awlen(usr_awlen),
        .usr_awsize(usr_awsize), .usr_awburst(usr_awburst),
        .usr_awvalid(usr_awvalid), .usr_awready(usr_awready),
        .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wlast(usr_wlast),
        .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
        .usr_bid(usr_bid), .usr_bresp(usr_bresp), .usr_bvalid(usr_bvalid),
        .usr_bready(usr_bready),
        .done(done), .err(err)
    );

    task automatic idle_inputs();
        cmd_valid   = 1'b0;
        src_valid   = 1'b0;
        usr_awready = 1'b0;
        usr_wready  = 1'b0;
        usr_bvalid  = 1'b0;
        usr_bresp   = 2'b00;
    endtask

    // One command end to end. mode: 0 random ready/valid, 1 wready toggling
    // 1/0, 2 full throughput. err_burst: burst answered with SLVERR (-1 none).
    // abort_beat: reset is pulsed once this many W beats have been accepted.
    task automatic run_cmd(input string name, input logic [31:0] addr, input int beats,
                           input int err_burst, input int mode, input int abort_beat);
        logic [31:0] b_addr[$];
        int          b_len[$];
        int          bidx[$];
        bit          last_flag[$];
        logic [DW-1:0] data[$];
        logic [31:0] a;
        logic [IW-1:0] id;
        int r, n, room, nb;
        int si, wi, awi, bi, pend, cyc;
        bit finished, aw_wait, exp_err, err_acc;
        bit aw_hs, w_hs, b_hs, s_hs;

        // Reference split: min(left, BL, beats to next 4 KB page), address wraps mod 2^32.
        a = addr; r = beats; nb = 0;
        while (r > 0) begin
            room = (4096 - int'(a[11:0])) / NB;
            n = (r < BLEN) ? r : BLEN;
            if (room < n) n = room;
            b_addr.push_back(a);
            b_len.push_back(n);
            for (int k = 0; k < n; k++) begin
                bidx.push_back(nb);
                last_flag.push_back(k == n - 1);
            end
            a = a + 32'(n * NB);
            r -= n;
            nb++;
        end
        for (int k = 0; k < beats; k++)
            data.push_back({$urandom, $urandom, $urandom, $urandom});
        exp_err = (err_burst >= 0) && (err_burst < nb);
        id = IW'($urandom);
        si = 0; wi = 0; awi = 0; bi = 0; pend = 0; cyc = 0;
        finished = 0; aw_wait = 0; err_acc = 0;

        @(posedge ACLK); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready got %b want 1", name, cmd_ready);
        end
        cmd_addr = addr; cmd_beats = CW'(beats); cmd_id = id; cmd_valid = 1'b1;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;

        while (!finished) begin
            if (cyc >= 5000) begin
                checks++; errors++;
                $display("FAIL %s timeout got beats=%0d bursts=%0d resp=%0d want %0d/%0d/%0d",
                         name, wi, awi, bi, beats, nb, nb);
                break;
            end
            src_valid = (si < beats) && (mode == 2 || $urandom_range(0, 3) != 0);
            if (si < beats) src_data = data[si];
            else            src_data = '0;
            usr_awready = (mode == 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (mode == 1)      usr_wready = (cyc % 2 == 0);
            else if (mode == 2) usr_wready = 1'b1;
            else                usr_wready = ($urandom_range(0, 3) != 0);
            if (!usr_bvalid && pend > 0 && $urandom_range(0, 2) == 0) begin
                usr_bvalid = 1'b1;
                usr_bid    = id;
                usr_bresp  = (bi == err_burst) ? 2'b10 : 2'b00;
            end

            @(negedge ACLK);

            if (abort_beat >= 0 && wi == abort_beat) begin
                ARESETn = 1'b0;
                #1;
                checks++;
                if ({usr_awvalid, usr_wvalid, src_ready, usr_bready, usr_wlast, done, err, cmd_ready} !== 8'b0000_0001) begin
                    errors++;
                    $display("FAIL %s reset_outputs got aw=%b w=%b sr=%b br=%b wl=%b done=%b err=%b cr=%b want 0000000 cr=1",
                             name, usr_awvalid, usr_wvalid, src_ready, usr_bready, usr_wlast, done, err, cmd_ready);
                end
                idle_inputs();
                @(posedge ACLK);
                @(negedge ACLK);
                ARESETn = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    @(negedge ACLK);
                    checks++;
                    if (done !== 1'b0 || usr_awvalid !== 1'b0 || usr_wvalid !== 1'b0 || cmd_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL %s post_reset got done=%b aw=%b w=%b cr=%b want 0 0 0 1",
                                 name, done, usr_awvalid, usr_wvalid, cmd_ready);
                    end
                end
                return;
            end

            aw_hs = usr_awvalid && usr_awready;
            w_hs  = usr_wvalid && usr_wready;
            b_hs  = usr_bvalid && usr_bready;
            s_hs  = src_valid && src_ready;

            checks++;
            if (err !== err_acc) begin
                errors++;
                $display("FAIL %s err_track got %b want %b", name, err, err_acc);
            end
            checks++;
            if (usr_awvalid === 1'b1 && usr_wvalid === 1'b1) begin
                errors++;
                $display("FAIL %s aw_w_overlap got awvalid=1 wvalid=1 want not both", name);
            end
            if (aw_wait) begin
                checks++;
                if (usr_awvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s awvalid_hold got %b want 1", name, usr_awvalid);
                end
            end
            if (usr_awvalid === 1'b1) begin
                checks++;
                if (awi >= nb) begin
                    errors++;
                    $display("FAIL %s extra_aw got addr=%h want only %0d bursts", name, usr_awaddr, nb);
                end else if (usr_awaddr !== b_addr[awi] || usr_awlen !== LW'(b_len[awi] - 1) ||
                             usr_awsize !== 3'd4 || usr_awburst !== 2'b01 || usr_awid !== id) begin
                    errors++;
                    $display("FAIL %s aw%0d got addr=%h len=%0d size=%0d burst=%b id=%h want addr=%h len=%0d size=4 burst=01 id=%h",
                             name, awi, usr_awaddr, usr_awlen, usr_awsize, usr_awburst, usr_awid,
                             b_addr[awi], b_len[awi] - 1, id);
                end
            end
            aw_wait = usr_awvalid && !usr_awready;
            checks++;
            if (s_hs !== w_hs) begin
                errors++;
                $display("FAIL %s src_w_hs got src_hs=%b w_hs=%b want equal", name, s_hs, w_hs);
            end
            if (usr_bvalid) begin
                checks++;
                if (usr_bready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s bready got %b want 1", name, usr_bready);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (bi != nb || wi != beats || awi != nb || err !== exp_err) begin
                    errors++;
                    $display("FAIL %s done got resp=%0d beats=%0d bursts=%0d err=%b want %0d/%0d/%0d err=%b",
                             name, bi, wi, awi, err, nb, beats, nb, exp_err);
                end
                finished = 1;
            end

            if (w_hs) begin
                checks++;
                if (wi >= beats) begin
                    errors++;
                    $display("FAIL %s extra_beat got beat %0d want %0d beats", name, wi, beats);
                end else begin
                    if (usr_wdata !== data[wi] || usr_wstrb !== {NB{1'b1}} ||
                        usr_wlast !== last_flag[wi] || bidx[wi] >= awi) begin
                        errors++;
                        $display("FAIL %s beat%0d got data=%h strb=%h last=%b aws=%0d want data=%h strb=ffff last=%b aws>%0d",
                                 name, wi, usr_wdata, usr_wstrb, usr_wlast, awi, data[wi], last_flag[wi], bidx[wi]);
                    end
                    if (last_flag[wi]) pend++;
                end
                wi++;
                si++;
            end
            if (b_hs) begin
                err_acc = err_acc | usr_bresp[1];
                bi++;
                pend--;
            end
            if (aw_hs) awi++;

            @(posedge ACLK); #1;
            if (b_hs) usr_bvalid = 1'b0;
            cyc++;
        end

        idle_inputs();
        @(negedge ACLK);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse got done=%b cmd_ready=%b want 0 1", name, done, cmd_ready);
        end
        $display("%s addr=%h beats=%0d bursts=%0d err=%b", name, addr, beats, nb, exp_err);
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        idle_inputs();
        cmd_addr = '0; cmd_beats = '0; cmd_id = '0; src_data = '0; usr_bid = '0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({usr_awvalid, usr_wvalid, src_ready, usr_bready, usr_wlast, done, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_in got aw=%b w=%b sr=%b br=%b wl=%b done=%b err=%b want all 0",
                     usr_awvalid, usr_wvalid, src_ready, usr_bready, usr_wlast, done, err);
        end
        ARESETn = 1'b1;
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1 || usr_awvalid !== 1'b0 || usr_bready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got cr=%b aw=%b br=%b done=%b want 1 0 0 0",
                     cmd_ready, usr_awvalid, usr_bready, done);
        end
        $display("reset done");
    endtask

    task automatic test_single_burst();
        run_cmd("single16", 32'h0, 16, -1, 0, -1);
    endtask

    task automatic test_page_cross();
        run_cmd("page_cross", 32'hFC0, 8, -1, 0, -1);
    endtask

    task automatic test_multi_burst();
        run_cmd("beats33", 32'h0, 33, -1, 0, -1);
    endtask

    task automatic test_backpressure();
        run_cmd("wready_toggle", 32'hF00, 40, -1, 1, -1);
    endtask

    task automatic test_error();
        run_cmd("slverr_second", 32'hFC0, 8, 1, 0, -1);
        run_cmd("after_err", 32'h2000, 5, -1, 0, -1);
    endtask

    task automatic test_abort();
        run_cmd("abort_beat5", 32'h0, 16, -1, 0, 4);
        run_cmd("post_abort", 32'h0, 16, -1, 0, -1);
    endtask

    task automatic test_addr_wrap();
        run_cmd("addr_wrap", 32'hFFFF_FFC0, 8, -1, 0, -1);
    endtask

    task automatic test_back_to_back();
        run_cmd("b2b_a", 32'h1F80, 20, -1, 2, -1);
        run_cmd("b2b_b", 32'h3000, 1, 0, 2, -1);
        run_cmd("b2b_c", 32'h4FF0, 17, -1, 2, -1);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int t = 0; t < 8; t++) begin
            addr = ($urandom & 32'hFFFF_F000) | (32'(4096 - 16 * $urandom_range(1, 40)) & 32'h0000_0FFF);
            run_cmd("random", addr, $urandom_range(1, 70), int'($urandom_range(0, 4)) - 1,
                    int'($urandom_range(0, 2)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_page_cross();
        test_multi_burst();
        test_backpressure();
        test_error();
        test_abort();
        test_addr_wrap();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
